// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
//   OP_*    : encoding of the registered RAM operation (what the RAM does next edge)
//   GRANT_* : which side won the most recent contested arbitration
package ram_fifo_ctrl_pkg;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;

  localparam logic GRANT_PUSH = 1'b0;
  localparam logic GRANT_POP  = 1'b1;

endpackage

// File: rtl/ram_fifo_ctrl_wrap_ptr.sv
// Wrapping FIFO pointer.
//   clk : clock
//   rst : synchronous active-high reset, clears ptr to 0
//   inc : advance ptr by one this edge (wraps at 2**W naturally)
//   ptr : current pointer value
module wrap_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sitting in front of a single-port synchronous RAM.
// Converts push/pop handshakes into registered RAM strobes, tracks
// occupancy and returns popped data with rd_valid.
//
// Handshake: a push is taken at a rising edge when push_valid && push_ready,
// a pop when pop_req && pop_ready. Readies are combinational from registered
// state and the opposite side's request; at most one of push/pop is taken
// per edge.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   push_valid/data/ready  : producer side
//   pop_req/pop_ready      : consumer side
//   rd_data, rd_valid      : popped word, valid two edges after the pop
//   full, empty, count     : occupancy status (0..DEPTH)
//   ram_addr/datain/read/write, ram_dataout : RAM interface
//   op_state               : registered operation state (OP_IDLE/OP_WR/OP_RD)
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic [1:0]        op_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              last_grant;
  logic [1:0]        rd_pipe;
  logic              push_elig;
  logic              pop_elig;
  logic              contested;
  logic              push_fire;
  logic              pop_fire;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign push_elig = push_valid && !full;
  assign pop_elig  = pop_req && !empty;
  assign contested = push_elig && pop_elig;

  // When both sides are eligible the one named in last_grant backs off,
  // so contested grants alternate; last_grant resets to POP so push wins first.
  assign push_ready = !full  && !(pop_elig  && last_grant == GRANT_PUSH);
  assign pop_ready  = !empty && !(push_elig && last_grant == GRANT_POP);

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_req && pop_ready;

  wrap_ptr #(.W(ADDR_W)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (push_fire),
    .ptr (wptr)
  );

  wrap_ptr #(.W(ADDR_W)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_fire),
    .ptr (rptr)
  );

  // Strobes decode straight from the registered op, so they can never overlap.
  assign ram_write = (op_state == OP_WR);
  assign ram_read  = (op_state == OP_RD);

  // RAM registers its output on the read edge; rd_data is a pass-through.
  assign rd_data  = ram_dataout;
  assign rd_valid = rd_pipe[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      last_grant <= GRANT_POP;
      op_state   <= OP_IDLE;
      ram_addr   <= '0;
      ram_datain <= '0;
      rd_pipe    <= '0;
    end else begin
      if (push_fire && !pop_fire) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (pop_fire && !push_fire) begin
        count <= count - (ADDR_W+1)'(1);
      end

      if (contested) begin
        last_grant <= push_fire ? GRANT_PUSH : GRANT_POP;
      end

      // Stage 0: read strobe is on the bus; stage 1: RAM output holds the word.
      rd_pipe <= {rd_pipe[0], pop_fire};

      if (push_fire) begin
        op_state   <= OP_WR;
        ram_addr   <= wptr;
        ram_datain <= push_data;
      end else if (pop_fire) begin
        op_state <= OP_RD;
        ram_addr <= rptr;
      end else begin
        op_state <= OP_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_req;
  logic              pop_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_datain;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_dataout;
  logic [1:0]        op_state;

  int checks;
  int failures;

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_wptr;
  logic [ADDR_W-1:0] exp_rptr;
  logic [DATA_W-1:0] mem [16];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .pop_req     (pop_req),
    .pop_ready   (pop_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .ram_addr    (ram_addr),
    .ram_datain  (ram_datain),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_dataout (ram_dataout),
    .op_state    (op_state)
  );

  // Behavioural synchronous RAM standing in for synchro_ram.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_datain;
    if (ram_read)  ram_dataout   <= mem[ram_addr];
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic do_push(input logic [DATA_W-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    pop_req    = 1'b0;
    #1;
    chk("push_ready", 32'(push_ready), 32'd1);
    @(negedge clk);
    push_valid = 1'b0;
    chk("push_write", 32'(ram_write), 32'd1);
    chk("push_addr", 32'(ram_addr), 32'(exp_wptr));
    chk("push_din", 32'(ram_datain), 32'(d));
    exp_q.push_back(d);
    exp_wptr = exp_wptr + 1'b1;
  endtask

  task automatic do_pop();
    logic [DATA_W-1:0] e;
    pop_req    = 1'b1;
    push_valid = 1'b0;
    #1;
    chk("pop_ready", 32'(pop_ready), 32'd1);
    @(negedge clk);
    pop_req = 1'b0;
    chk("pop_read", 32'(ram_read), 32'd1);
    chk("pop_addr", 32'(ram_addr), 32'(exp_rptr));
    chk("pop_early_valid", 32'(rd_valid), 32'd0);
    exp_rptr = exp_rptr + 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", 32'(rd_data), 32'(e));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    exp_wptr   = '0;
    exp_rptr   = '0;
    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    pop_req    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_read", 32'(ram_read), 32'd0);
    chk("rst_write", 32'(ram_write), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_datain), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);

    // Pop on empty is refused
    pop_req = 1'b1;
    #1;
    chk("empty_pop_ready", 32'(pop_ready), 32'd0);
    @(negedge clk);
    chk("empty_pop_read", 32'(ram_read), 32'd0);
    @(negedge clk);
    chk("empty_pop_valid", 32'(rd_valid), 32'd0);
    chk("empty_pop_count", 32'(count), 32'd0);
    pop_req = 1'b0;

    // Push 4,6,1,A then pop four
    do_push(4'h4);
    do_push(4'h6);
    do_push(4'h1);
    do_push(4'hA);
    chk("t1_count4", 32'(count), 32'd4);
    chk("t1_not_empty", 32'(empty), 32'd0);
    do_pop();
    do_pop();
    chk("t1_count2", 32'(count), 32'd2);
    do_pop();
    do_pop();
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill to 16, push is blocked, one pop reopens it
    for (int i = 0; i < 16; i++) do_push(4'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count16", 32'(count), 32'd16);
    chk("t2_ready_idle", 32'(push_ready), 32'd0);
    push_valid = 1'b1;
    push_data  = 4'h7;
    #1;
    chk("t2_ready_held", 32'(push_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t2_no_write", 32'(ram_write), 32'd0);
      chk("t2_count_held", 32'(count), 32'd16);
    end
    push_valid = 1'b0;
    do_pop();
    chk("t2_count15", 32'(count), 32'd15);
    chk("t2_not_full", 32'(full), 32'd0);
    chk("t2_ready_back", 32'(push_ready), 32'd1);
    for (int i = 0; i < 15; i++) do_pop();
    chk("t2_drained", 32'(empty), 32'd1);

    // Contested arbitration: two words preloaded, then both requests held
    do_push(4'h3);
    do_push(4'h5);
    push_valid = 1'b1;
    pop_req    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [DATA_W-1:0] e;
      push_data = 4'(8 + i);
      @(negedge clk);
      chk("t4_write", 32'(ram_write), 32'((i % 2) == 0));
      chk("t4_read", 32'(ram_read), 32'((i % 2) == 1));
      chk("t4_count", 32'(count), ((i % 2) == 0) ? 32'd3 : 32'd2);
      if ((i % 2) == 0) begin
        chk("t4_wr_addr", 32'(ram_addr), 32'(exp_wptr));
        chk("t4_din", 32'(ram_datain), 32'(8 + i));
        exp_q.push_back(4'(8 + i));
        exp_wptr = exp_wptr + 1'b1;
      end else begin
        chk("t4_rd_addr", 32'(ram_addr), 32'(exp_rptr));
        exp_rptr = exp_rptr + 1'b1;
      end
      chk("t4_valid", 32'(rd_valid), 32'(i == 2 || i == 4));
      if (i == 2 || i == 4) begin
        e = exp_q.pop_front();
        chk("t4_data", 32'(rd_data), 32'(e));
      end
    end
    push_valid = 1'b0;
    pop_req    = 1'b0;
    @(negedge clk);
    chk("t4_last_valid", 32'(rd_valid), 32'd1);
    chk("t4_last_data", 32'(rd_data), 32'(exp_q.pop_front()));
    do_pop();
    do_pop();
    chk("t4_empty", 32'(empty), 32'd1);

    // 20 push/pop pairs carry both pointers across the 15->0 wrap
    for (int i = 0; i < 20; i++) begin
      do_push(4'((i * 7 + 3) % 16));
      do_pop();
    end
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_count", 32'(count), 32'd0);

    // Reset one cycle after a pop accept drops the pending rd_valid
    do_push(4'h9);
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    chk("t6_read", 32'(ram_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_wptr = '0;
    exp_rptr = '0;
    chk("t6_valid_dropped", 32'(rd_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_read_clr", 32'(ram_read), 32'd0);
    @(negedge clk);
    chk("t6_valid_still0", 32'(rd_valid), 32'd0);
    do_push(4'hF);
    do_pop();
    chk("t6_end_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
